// File: rtl/playfield_mem_pkg.sv
// Shared definitions for the playfield memory: default geometry and the
// control FSM state encoding.
package playfield_mem_pkg;

  localparam int unsigned PF_MEM_WIDTH  = 4;  // playfield columns
  localparam int unsigned PF_MEM_HEIGHT = 4;  // playfield rows, row 0 on top
  localparam int unsigned PF_WIDTH      = 8;  // coordinate / bus / counter field width
  localparam int unsigned PF_CELLS      = 4;  // cells per piece

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    SCAN  = 2'd2,
    SHIFT = 2'd3
  } pf_state_e;

endpackage

// File: rtl/playfield_mem_surface_calc.sv
// Combinational surface extraction: for every column, the index of the
// topmost occupied row, or MEM_HEIGHT when the column is empty.
// Ports:
//   i_grid  grid, i_grid[row][col], 1 = occupied
//   o_bus   per-column surface row, column 0 in the MSBs
module playfield_mem_surface_calc
  import playfield_mem_pkg::*;
#(
  parameter int unsigned MEM_WIDTH  = PF_MEM_WIDTH,
  parameter int unsigned MEM_HEIGHT = PF_MEM_HEIGHT,
  parameter int unsigned WIDTH      = PF_WIDTH
) (
  input  logic [MEM_HEIGHT-1:0][MEM_WIDTH-1:0] i_grid,
  output logic [WIDTH*MEM_WIDTH-1:0]           o_bus
);

  always_comb begin
    o_bus = '0;
    for (int unsigned c = 0; c < MEM_WIDTH; c++) begin
      o_bus[WIDTH*(MEM_WIDTH-c)-1 -: WIDTH] = WIDTH'(MEM_HEIGHT);
      // Walk bottom-up so the topmost occupied row is written last.
      for (int unsigned i = 0; i < MEM_HEIGHT; i++) begin
        if (i_grid[MEM_HEIGHT-1-i][c]) begin
          o_bus[WIDTH*(MEM_WIDTH-c)-1 -: WIDTH] = WIDTH'(MEM_HEIGHT-1-i);
        end
      end
    end
  end

endmodule

// File: rtl/playfield_mem.sv
// Playfield memory: commits a four-cell piece into the grid, then clears
// full rows bottom-up, shifting the rows above down by one per cycle.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   is_write_mem   one-cycle commit request
//   coord_x/_y     cell 0..3 coordinates, cell 0 in the MSBs
//   bus            per-column surface row, column 0 in the MSBs
//   busy           commit or clear in progress
//   done           one-cycle pulse when a commit fully completes
//   dropped        one-cycle pulse when a request arrives while busy
//   lines          running count of cleared rows
module playfield_mem
  import playfield_mem_pkg::*;
#(
  parameter int unsigned MEM_WIDTH  = PF_MEM_WIDTH,
  parameter int unsigned MEM_HEIGHT = PF_MEM_HEIGHT,
  parameter int unsigned WIDTH      = PF_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       is_write_mem,
  input  logic [WIDTH*PF_CELLS-1:0]  coord_x,
  input  logic [WIDTH*PF_CELLS-1:0]  coord_y,
  output logic [WIDTH*MEM_WIDTH-1:0] bus,
  output logic                       busy,
  output logic                       done,
  output logic                       dropped,
  output logic [WIDTH-1:0]           lines
);

  pf_state_e r_state, w_next_state;

  logic [MEM_HEIGHT-1:0][MEM_WIDTH-1:0] r_grid;
  logic [MEM_HEIGHT-1:0][MEM_WIDTH-1:0] w_mask;
  logic [MEM_HEIGHT-1:0][MEM_WIDTH-1:0] w_shift_src;
  logic [WIDTH*PF_CELLS-1:0]            r_cx, r_cy;
  logic [WIDTH-1:0]                     r_scan, r_shift, r_lines;
  logic                                 r_done, r_dropped;
  logic w_row_full, w_scan_zero, w_shift_zero, w_eval, w_full, w_finish;

  assign w_scan_zero  = (r_scan == '0);
  assign w_shift_zero = (r_shift == '0);

  // The last SHIFT step (s=0) also performs the re-scan of the scan row:
  // rows >= 1 already hold their final shifted contents by then, so the
  // scan decision is taken in that cycle instead of a separate SCAN cycle.
  // Row 0 is being emptied in that step, so it can never re-test as full.
  assign w_eval = (r_state == SCAN) || (r_state == SHIFT && w_shift_zero);
  assign w_full = (r_state == SHIFT) ? (w_row_full && !w_scan_zero) : w_row_full;

  always_comb begin
    w_row_full = 1'b0;
    for (int unsigned r = 0; r < MEM_HEIGHT; r++) begin
      if (r_scan == WIDTH'(r)) w_row_full = &r_grid[r];
    end
  end

  // Out-of-range cells match no grid position and are simply skipped.
  always_comb begin
    w_mask = '0;
    for (int unsigned k = 0; k < PF_CELLS; k++) begin
      for (int unsigned r = 0; r < MEM_HEIGHT; r++) begin
        for (int unsigned c = 0; c < MEM_WIDTH; c++) begin
          if (r_cx[WIDTH*(PF_CELLS-k)-1 -: WIDTH] == WIDTH'(c) &&
              r_cy[WIDTH*(PF_CELLS-k)-1 -: WIDTH] == WIDTH'(r)) begin
            w_mask[r][c] = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    w_shift_src = '0;
    for (int unsigned r = 1; r < MEM_HEIGHT; r++) begin
      w_shift_src[r] = r_grid[r-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_finish     = 1'b0;
    case (r_state)
      IDLE:  if (is_write_mem) w_next_state = WRITE;
      WRITE: w_next_state = SCAN;
      SCAN, SHIFT: begin
        if (w_eval) begin
          if (w_full) begin
            w_next_state = SHIFT;
          end else if (w_scan_zero) begin
            w_next_state = IDLE;
            w_finish     = 1'b1;
          end else begin
            w_next_state = SCAN;
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grid    <= '0;
      r_cx      <= '0;
      r_cy      <= '0;
      r_scan    <= '0;
      r_shift   <= '0;
      r_lines   <= '0;
      r_done    <= 1'b0;
      r_dropped <= 1'b0;
    end else begin
      r_done    <= w_finish;
      r_dropped <= is_write_mem && (r_state != IDLE);
      if (r_state == IDLE && is_write_mem) begin
        r_cx <= coord_x;
        r_cy <= coord_y;
      end
      if (r_state == WRITE) begin
        r_grid <= r_grid | w_mask;
        r_scan <= WIDTH'(MEM_HEIGHT - 1);
      end
      if (r_state == SHIFT) begin
        for (int unsigned r = 0; r < MEM_HEIGHT; r++) begin
          if (r_shift == WIDTH'(r)) r_grid[r] <= w_shift_src[r];
        end
        if (w_shift_zero) r_lines <= r_lines + WIDTH'(1);
        else              r_shift <= r_shift - WIDTH'(1);
      end
      if (w_eval) begin
        if (w_full)            r_shift <= r_scan;
        else if (!w_scan_zero) r_scan  <= r_scan - WIDTH'(1);
      end
    end
  end

  playfield_mem_surface_calc #(
    .MEM_WIDTH (MEM_WIDTH),
    .MEM_HEIGHT(MEM_HEIGHT),
    .WIDTH     (WIDTH)
  ) u_surface_calc (
    .i_grid(r_grid),
    .o_bus (bus)
  );

  assign busy    = (r_state != IDLE);
  assign done    = r_done;
  assign dropped = r_dropped;
  assign lines   = r_lines;

endmodule

// File: tb/tb_playfield_mem.sv
// Self-checking bench for playfield_mem (default 4x4 geometry, 8-bit fields).
module tb_playfield_mem;

  localparam int H = 4;
  localparam int W = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        is_write_mem;
  logic [31:0] coord_x, coord_y;
  logic [31:0] bus;
  logic        busy, done, dropped;
  logic [7:0]  lines;

  always #5 clk = ~clk;

  playfield_mem #(
    .MEM_WIDTH (4),
    .MEM_HEIGHT(4),
    .WIDTH     (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .is_write_mem(is_write_mem),
    .coord_x     (coord_x),
    .coord_y     (coord_y),
    .bus         (bus),
    .busy        (busy),
    .done        (done),
    .dropped     (dropped),
    .lines       (lines)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_grid[H][W];
  int m_lines;

  function automatic void model_clear();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) m_grid[r][c] = 0;
    m_lines = 0;
  endfunction

  function automatic logic [31:0] model_bus();
    logic [31:0] res;
    res = '0;
    for (int c = 0; c < W; c++) begin
      int top;
      top = H;
      for (int r = 0; r < H; r++)
        if (m_grid[r][c] != 0 && top == H) top = r;
      res[8*(W-1-c) +: 8] = 8'(top);
    end
    return res;
  endfunction

  // Full rows are removed and the rest compacted downward. A full row at
  // original index i is met at position i + (full rows below it) and its
  // clear costs that position + 1 cycles on top of the 1 + H baseline.
  function automatic int model_commit(input logic [31:0] x, input logic [31:0] y);
    bit full[H];
    int nxt[H][W];
    int lat, pos, nfull;
    for (int k = 0; k < 4; k++) begin
      int xv, yv;
      xv = int'(x[8*(3-k) +: 8]);
      yv = int'(y[8*(3-k) +: 8]);
      if (xv < W && yv < H) m_grid[yv][xv] = 1;
    end
    nfull = 0;
    for (int r = 0; r < H; r++) begin
      full[r] = 1'b1;
      for (int c = 0; c < W; c++) if (m_grid[r][c] == 0) full[r] = 1'b0;
      if (full[r]) nfull++;
    end
    lat = 1 + H;
    for (int i = 0; i < H; i++) begin
      if (full[i]) begin
        int below;
        below = 0;
        for (int j = i + 1; j < H; j++) if (full[j]) below++;
        lat += i + below + 1;
      end
    end
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) nxt[r][c] = 0;
    pos = H - 1;
    for (int r = H - 1; r >= 0; r--) begin
      if (!full[r]) begin
        for (int c = 0; c < W; c++) nxt[pos][c] = m_grid[r][c];
        pos--;
      end
    end
    m_grid  = nxt;
    m_lines = (m_lines + nfull) % 256;
    return lat;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic apply_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_done(output int cyc, output bit got);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (done) got = 1'b1;
    end
    check("done_seen", 64'(got), 64'd1);
  endtask

  // Called at the #1-after-posedge phase; returns cycles from the request
  // edge to the edge after which done is observed.
  task automatic do_commit(input logic [31:0] x, input logic [31:0] y, output int lat);
    bit got;
    coord_x      = x;
    coord_y      = y;
    is_write_mem = 1'b1;
    @(posedge clk); #1;
    is_write_mem = 1'b0;
    check("busy_rise", 64'(busy), 64'd1);
    wait_done(lat, got);
    if (got) begin
      check("busy_at_done", 64'(busy), 64'd0);
      @(posedge clk); #1;
      check("done_width", 64'(done), 64'd0);
    end
  endtask

  typedef struct {
    bit          rst_first;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] exp_bus;
    int          exp_lines;
    int          exp_lat;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int lat;
    bit got;

    rst          = 1'b1;
    is_write_mem = 1'b0;
    coord_x      = '0;
    coord_y      = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;

    check("reset_bus",     64'(bus),     64'h04040404);
    check("reset_busy",    64'(busy),    64'd0);
    check("reset_lines",   64'(lines),   64'd0);
    check("reset_done",    64'(done),    64'd0);
    check("reset_dropped", 64'(dropped), 64'd0);

    tbl[0] = '{1'b1, {8'd0,8'd1,8'd2,8'd2}, {8'd3,8'd3,8'd3,8'd2}, {8'd3,8'd3,8'd2,8'd4}, 0, 5};
    tbl[1] = '{1'b1, {8'd1,8'd1,8'd1,8'd1}, {8'd2,8'd2,8'd2,8'd2}, {8'd4,8'd2,8'd4,8'd4}, 0, 5};
    tbl[2] = '{1'b0, {8'd0,8'd1,8'd2,8'd3}, {8'd3,8'd3,8'd3,8'd3}, {8'd4,8'd3,8'd4,8'd4}, 1, 9};
    tbl[3] = '{1'b1, {8'd5,8'd1,8'd2,8'd3}, {8'd3,8'd3,8'd3,8'd3}, {8'd4,8'd3,8'd3,8'd3}, 0, 5};
    tbl[4] = '{1'b0, {8'd9,8'd9,8'd9,8'd9}, {8'd0,8'd9,8'd0,8'd9}, {8'd4,8'd3,8'd3,8'd3}, 0, 5};
    tbl[5] = '{1'b0, {8'd0,8'd0,8'd1,8'd2}, {8'd3,8'd2,8'd2,8'd2}, {8'd3,8'd3,8'd3,8'd4}, 1, 9};
    tbl[6] = '{1'b1, {8'd0,8'd1,8'd0,8'd1}, {8'd3,8'd3,8'd2,8'd2}, {8'd2,8'd2,8'd4,8'd4}, 0, 5};
    tbl[7] = '{1'b0, {8'd2,8'd3,8'd2,8'd3}, {8'd3,8'd3,8'd2,8'd2}, {8'd4,8'd4,8'd4,8'd4}, 2, 13};
    tbl[8] = '{1'b0, {8'd0,8'd1,8'd2,8'd3}, {8'd0,8'd0,8'd0,8'd0}, {8'd4,8'd4,8'd4,8'd4}, 3, 6};

    for (int i = 0; i < 9; i++) begin
      if (tbl[i].rst_first) apply_reset();
      do_commit(tbl[i].x, tbl[i].y, lat);
      check($sformatf("tbl%0d_latency", i), 64'(lat),   64'(tbl[i].exp_lat));
      check($sformatf("tbl%0d_bus", i),     64'(bus),   64'(tbl[i].exp_bus));
      check($sformatf("tbl%0d_lines", i),   64'(lines), 64'(tbl[i].exp_lines));
    end

    // Second request two cycles after the first is dropped.
    apply_reset();
    coord_x      = {8'd0,8'd1,8'd2,8'd2};
    coord_y      = {8'd3,8'd3,8'd3,8'd2};
    is_write_mem = 1'b1;
    @(posedge clk); #1;
    is_write_mem = 1'b0;
    coord_x      = {8'd3,8'd3,8'd3,8'd3};
    coord_y      = {8'd0,8'd1,8'd2,8'd3};
    check("drop_before", 64'(dropped), 64'd0);
    @(posedge clk); #1;
    is_write_mem = 1'b1;
    @(posedge clk); #1;
    is_write_mem = 1'b0;
    check("drop_pulse", 64'(dropped), 64'd1);
    @(posedge clk); #1;
    check("drop_width", 64'(dropped), 64'd0);
    wait_done(lat, got);
    check("drop_lat_tail", 64'(lat), 64'd2);
    check("drop_bus",      64'(bus), 64'h03030204);
    repeat (2) @(posedge clk);
    #1;
    check("drop_no_second", 64'(busy), 64'd0);

    // Reset asserted while rows are shifting.
    apply_reset();
    coord_x      = {8'd0,8'd1,8'd2,8'd3};
    coord_y      = {8'd3,8'd3,8'd3,8'd3};
    is_write_mem = 1'b1;
    @(posedge clk); #1;
    is_write_mem = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("shift_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("midrst_bus",   64'(bus),   64'h04040404);
    check("midrst_busy",  64'(busy),  64'd0);
    check("midrst_lines", 64'(lines), 64'd0);
    check("midrst_done",  64'(done),  64'd0);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (k == 2) rst = 1'b0;
      check("midrst_no_done", 64'(done), 64'd0);
    end
    do_commit({8'd0,8'd1,8'd2,8'd2}, {8'd3,8'd3,8'd3,8'd2}, lat);
    check("after_rst_lat",   64'(lat),   64'd5);
    check("after_rst_bus",   64'(bus),   64'h03030204);
    check("after_rst_lines", 64'(lines), 64'd0);

    // Randomized commits against the reference model.
    apply_reset();
    model_clear();
    for (int n = 0; n < 48; n++) begin
      logic [31:0] x, y;
      int exp_lat;
      if (n > 0 && n % 12 == 0) begin
        apply_reset();
        model_clear();
      end
      for (int k = 0; k < 4; k++) begin
        int yv;
        yv = int'($urandom_range(0, 4));
        if ($urandom_range(0, 1) == 1) yv = int'($urandom_range(2, 3));
        x[8*(3-k) +: 8] = 8'($urandom_range(0, 4));
        y[8*(3-k) +: 8] = 8'(yv);
      end
      exp_lat = model_commit(x, y);
      do_commit(x, y, lat);
      check($sformatf("rnd%0d_latency", n), 64'(lat),   64'(exp_lat));
      check($sformatf("rnd%0d_bus", n),     64'(bus),   64'(model_bus()));
      check($sformatf("rnd%0d_lines", n),   64'(lines), 64'(m_lines));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
